mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, meaning the number of consecutive memory-wait cycles before the controller aborts the access.
REQ-002 clk_i  input  1  clock; all state changes on its rising edge.
REQ-003 reset_ni  input  1  asynchronous, active-low reset.
REQ-004 opcode_i6  input  6  instruction register bits [31:26].
REQ-005 funct_i6  input  6  instruction register bits [5:0].
REQ-006 zero_i  input  1  ALU zero flag.
REQ-007 mem_ready_i  input  1  memory completes the current access this cycle.
REQ-008 mem_req_o  output  1  memory access request.
REQ-009 iord_o, mem_write_o, ir_write_o, pc_write_o  output  1 each  address select (0 = PC, 1 = ALU result), store strobe, instruction register load, unconditional PC load.
REQ-010 branch_o, reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o  output  1 each  standard multicycle datapath controls.
REQ-011 alu_src_b_o2  output  2  ALU source B: 00 = register, 01 = constant 4, 10 = extended immediate, 11 = extended immediate shifted left by 2.
REQ-012 pc_src_o2  output  2  next-PC source: 00 = ALU, 01 = ALU result register, 10 = jump target.
REQ-013 alu_control_o4  output  4  ALU operation: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111.
REQ-014 imm_ext_type_o, alu_skip_o  output  1 each  immediate extension type (0 = sign, 1 = upper) and ALU bypass.
REQ-015 state_o4  output  4  current state encoding, for debug.
REQ-016 illegal_o, bus_err_o  output  1 each  one-cycle error pulses.

Function
REQ-017 The controller SHALL be a Moore FSM; every output is decoded from the current state only, except that ir_write_o, pc_write_o and mem_write_o are additionally qualified by mem_ready_i as stated below.
REQ-018 States and encodings SHALL be FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BEQ 8, ADDIEX 9, ADDIWB 10, JUMP 11, LUIEX 12.
REQ-019 FETCH SHALL assert mem_req_o, iord_o = 0, alu_src_a_o = 0, alu_src_b_o2 = 01, ADD, and pc_src_o2 = 00; ir_write_o and pc_write_o SHALL be asserted only in the cycle in which mem_ready_i = 1; the FSM advances to DECODE on that edge and holds FETCH otherwise.
REQ-020 DECODE SHALL drive alu_src_b_o2 = 11 with ADD and branch on opcode:
- 100011 (lw) or 101011 (sw) -> MEMADR
- 000000 -> EXEC
- 000100 -> BEQ
- 001000 -> ADDIEX
- 000010 -> JUMP
- any other opcode -> FETCH, with illegal_o pulsed.
REQ-021 MEMADR SHALL drive alu_src_a_o = 1, alu_src_b_o2 = 10 and ADD, then go to MEMRD for lw or MEMWR for sw.
REQ-022 MEMRD and MEMWR SHALL assert mem_req_o and iord_o = 1 and hold until mem_ready_i; MEMWR pulses mem_write_o only in the ready cycle and then goes to FETCH; MEMRD goes to MEMWB.
REQ-023 MEMWB SHALL assert reg_write_o and mem_to_reg_o with reg_dst_o = 0.
REQ-024 EXEC SHALL drive alu_src_a_o = 1 and alu_src_b_o2 = 00, with alu_control_o4 decoded from funct_i6 (100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT); any other funct SHALL pulse illegal_o and return to FETCH; otherwise the FSM goes to ALUWB.
REQ-025 ALUWB SHALL assert reg_write_o with reg_dst_o = 1.
REQ-026 BEQ SHALL drive alu_src_a_o = 1, alu_src_b_o2 = 00, SUB, branch_o = 1 and pc_src_o2 = 01.
REQ-027 ADDIEX SHALL drive alu_src_a_o = 1, alu_src_b_o2 = 10 and ADD; ADDIWB SHALL assert reg_write_o with reg_dst_o = 0.
REQ-028 JUMP SHALL assert pc_write_o with pc_src_o2 = 10.
REQ-029 MEMWB, ALUWB, BEQ, ADDIWB, JUMP and LUIEX SHALL return to FETCH.
REQ-030 A wait counter SHALL count consecutive not-ready cycles in FETCH, MEMRD and MEMWR and clear on every state change.
REQ-031 When the wait counter reaches TIMEOUT_CYCLES-1 with mem_ready_i still 0, the controller SHALL pulse bus_err_o, perform no writes, and go to FETCH; the PC is unchanged on a FETCH timeout.
REQ-032 Any output not driven by a state SHALL be 0.

Reset
REQ-033 Assertion of reset_ni SHALL immediately force state FETCH, clear the wait counter, and drive both error pulses to 0, including mid-access.
REQ-034 While reset_ni is low, the write strobes ir_write_o, pc_write_o, mem_write_o and reg_write_o SHALL be 0, regardless of mem_ready_i.

Configuration
REQ-035 With MC_CTRL_LUI_EN defined, DECODE SHALL send opcode 001111 to LUIEX, which asserts imm_ext_type_o = 1, alu_skip_o = 1, reg_write_o and reg_dst_o = 0.
REQ-036 Without MC_CTRL_LUI_EN, opcode 001111 SHALL be illegal, and imm_ext_type_o and alu_skip_o SHALL be tied to 0.

Verification
REQ-037 lw with mem_ready_i high in every cycle -> state sequence 0,1,2,3,4,0; reg_write_o and mem_to_reg_o high only in state 4.
REQ-038 add (funct 100000) with FETCH ready delayed 3 cycles -> FETCH held 4 cycles, single ir_write_o pulse, then states 1,6,7 with alu_control_o4 = 0010.
REQ-039 beq -> BEQ state with branch_o = 1, pc_src_o2 = 01, alu_control_o4 = 0110.
REQ-040 Opcode 111111 -> one illegal_o pulse, FETCH next cycle; funct 000111 in EXEC -> same result.
REQ-041 sw with mem_ready_i held low for 16 cycles -> bus_err_o pulse, no mem_write_o, FETCH next.
REQ-042 reset_ni driven low while in MEMRD -> state_o4 = 0 immediately and all write strobes 0; with MC_CTRL_LUI_EN defined, opcode 001111 -> LUIEX with imm_ext_type_o = 1.

Source files
------------

// File: rtl/mc_controller.sv
// Multicycle MIPS-subset control FSM (Moore), one state per cycle; FETCH/MEMRD/MEMWR stall on mem_ready_i low
// and abort to FETCH with bus_err_o after TIMEOUT_CYCLES waits. Define MC_CTRL_LUI_EN to add the LUIEX state.
module mc_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic [5:0] opcode_i6,
    input  logic [5:0] funct_i6,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       mem_req_o,
    output logic       iord_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       pc_write_o,
    output logic       branch_o,
    output logic       reg_write_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o2,
    output logic [1:0] pc_src_o2,
    output logic [3:0] alu_control_o4,
    output logic       imm_ext_type_o,
    output logic       alu_skip_o,
    output logic [3:0] state_o4,
    output logic       illegal_o,
    output logic       bus_err_o
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BEQ    = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11,
        LUIEX  = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
`ifdef MC_CTRL_LUI_EN
    localparam logic [5:0] OP_LUI   = 6'b001111;
`endif

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam int unsigned WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYCLES - 1);

    state_t        state_q, state_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic          illegal_q, illegal_d;
    logic          bus_err_q, bus_err_d;
    logic          waiting, timeout;
    logic          funct_ok;
    logic [3:0]    funct_alu;

    // Branch condition is resolved in the datapath from branch_o and the ALU zero flag.
    logic unused_zero;
    assign unused_zero = zero_i;

    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = 4'b0000;
        case (funct_i6)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
            default:   funct_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= FETCH;
            wcnt_q    <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        bus_err_d = 1'b0;
        waiting   = ((state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR)) && !mem_ready_i;
        timeout   = waiting && (wcnt_q == WAIT_LAST);
        case (state_q)
            FETCH:  if (mem_ready_i) state_d = DECODE;
            DECODE: begin
                case (opcode_i6)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXEC;
                    OP_BEQ:       state_d = BEQ;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
`ifdef MC_CTRL_LUI_EN
                    OP_LUI:       state_d = LUIEX;
`endif
                    default: begin
                        state_d   = FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            MEMADR: state_d = (opcode_i6 == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  if (mem_ready_i) state_d = MEMWB;
            MEMWR:  if (mem_ready_i) state_d = FETCH;
            EXEC: begin
                if (funct_ok) begin
                    state_d = ALUWB;
                end else begin
                    state_d   = FETCH;
                    illegal_d = 1'b1;
                end
            end
            ADDIEX: state_d = ADDIWB;
            default: state_d = FETCH;
        endcase
        if (timeout) begin
            state_d   = FETCH;
            bus_err_d = 1'b1;
        end
        // A FETCH timeout stays in FETCH, so the count restarts explicitly.
        if (timeout || (state_d != state_q)) begin
            wcnt_d = '0;
        end else if (waiting) begin
            wcnt_d = wcnt_q + WW'(1);
        end else begin
            wcnt_d = wcnt_q;
        end
    end

    always_comb begin
        mem_req_o      = 1'b0;
        iord_o         = 1'b0;
        mem_write_o    = 1'b0;
        ir_write_o     = 1'b0;
        pc_write_o     = 1'b0;
        branch_o       = 1'b0;
        reg_write_o    = 1'b0;
        reg_dst_o      = 1'b0;
        mem_to_reg_o   = 1'b0;
        alu_src_a_o    = 1'b0;
        alu_src_b_o2   = 2'b00;
        pc_src_o2      = 2'b00;
        alu_control_o4 = 4'b0000;
        imm_ext_type_o = 1'b0;
        alu_skip_o     = 1'b0;
        case (state_q)
            FETCH: begin
                mem_req_o      = 1'b1;
                alu_src_b_o2   = 2'b01;
                alu_control_o4 = ALU_ADD;
                // Reset sits in FETCH, so the strobes must also be masked by reset_ni.
                ir_write_o     = mem_ready_i & reset_ni;
                pc_write_o     = mem_ready_i & reset_ni;
            end
            DECODE: begin
                alu_src_b_o2   = 2'b11;
                alu_control_o4 = ALU_ADD;
            end
            MEMADR, ADDIEX: begin
                alu_src_a_o    = 1'b1;
                alu_src_b_o2   = 2'b10;
                alu_control_o4 = ALU_ADD;
            end
            MEMRD: begin
                mem_req_o = 1'b1;
                iord_o    = 1'b1;
            end
            MEMWR: begin
                mem_req_o   = 1'b1;
                iord_o      = 1'b1;
                mem_write_o = mem_ready_i;
            end
            MEMWB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
            end
            EXEC: begin
                alu_src_a_o    = 1'b1;
                alu_control_o4 = funct_alu;
            end
            ALUWB: begin
                reg_write_o = 1'b1;
                reg_dst_o   = 1'b1;
            end
            BEQ: begin
                alu_src_a_o    = 1'b1;
                alu_control_o4 = ALU_SUB;
                branch_o       = 1'b1;
                pc_src_o2      = 2'b01;
            end
            ADDIWB: reg_write_o = 1'b1;
            JUMP: begin
                pc_write_o = 1'b1;
                pc_src_o2  = 2'b10;
            end
`ifdef MC_CTRL_LUI_EN
            LUIEX: begin
                imm_ext_type_o = 1'b1;
                alu_skip_o     = 1'b1;
                reg_write_o    = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign state_o4  = state_q;
    assign illegal_o = illegal_q;
    assign bus_err_o = bus_err_q;

endmodule

// File: tb/tb_mc_controller.sv
// Randomized bench for mc_controller: each instruction is expanded into an expected per-cycle
// trace (state, outputs, mem_ready_i) from the instruction class and chosen wait lengths.
module tb_mc_controller;

    localparam int TMO = 16;

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
                           S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_EXEC = 4'd6, S_ALUWB = 4'd7,
                           S_BEQ = 4'd8, S_ADDIEX = 4'd9, S_ADDIWB = 4'd10, S_JUMP = 4'd11,
                           S_LUIEX = 4'd12;

    localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_BEQ = 6'b000100,
                           OP_ADDI = 6'b001000, OP_LUI = 6'b001111, OP_LW = 6'b100011,
                           OP_SW = 6'b101011;

    logic       clk;
    logic       reset_ni;
    logic [5:0] opcode_i6;
    logic [5:0] funct_i6;
    logic       zero_i;
    logic       mem_ready_i;
    logic       mem_req_o, iord_o, mem_write_o, ir_write_o, pc_write_o;
    logic       branch_o, reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o;
    logic [1:0] alu_src_b_o2, pc_src_o2;
    logic [3:0] alu_control_o4, state_o4;
    logic       imm_ext_type_o, alu_skip_o, illegal_o, bus_err_o;

    mc_controller #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk), .reset_ni(reset_ni), .opcode_i6(opcode_i6), .funct_i6(funct_i6),
        .zero_i(zero_i), .mem_ready_i(mem_ready_i), .mem_req_o(mem_req_o), .iord_o(iord_o),
        .mem_write_o(mem_write_o), .ir_write_o(ir_write_o), .pc_write_o(pc_write_o),
        .branch_o(branch_o), .reg_write_o(reg_write_o), .reg_dst_o(reg_dst_o),
        .mem_to_reg_o(mem_to_reg_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o2(alu_src_b_o2),
        .pc_src_o2(pc_src_o2), .alu_control_o4(alu_control_o4), .imm_ext_type_o(imm_ext_type_o),
        .alu_skip_o(alu_skip_o), .state_o4(state_o4), .illegal_o(illegal_o), .bus_err_o(bus_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       rdy;
        logic       ill;
        logic       berr;
    } cyc_t;

    cyc_t plan[$];
    logic pend_ill, pend_berr;
    int   n_checks, n_errors;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    // {legal, alu code} for an R-type funct field.
    function automatic logic [4:0] r_alu(input logic [5:0] fn);
        case (fn)
            6'b100000: return {1'b1, 4'b0010};
            6'b100010: return {1'b1, 4'b0110};
            6'b100100: return {1'b1, 4'b0000};
            6'b100101: return {1'b1, 4'b0001};
            6'b101010: return {1'b1, 4'b0111};
            default:   return 5'b0;
        endcase
    endfunction

    function automatic logic [21:0] dut_outs();
        return {mem_req_o, iord_o, mem_write_o, ir_write_o, pc_write_o, branch_o, reg_write_o,
                reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o2, pc_src_o2, alu_control_o4,
                imm_ext_type_o, alu_skip_o, illegal_o, bus_err_o};
    endfunction

    // Output values each state must show, straight from the controller's state table.
    function automatic logic [21:0] exp_outs(input cyc_t e, input logic [5:0] fn);
        logic req = 0, io = 0, mw = 0, irw = 0, pcw = 0, br = 0, rw = 0, rd = 0, m2r = 0, sa = 0;
        logic imm = 0, skip = 0;
        logic [1:0] sb = 2'b00, ps = 2'b00;
        logic [3:0] alu = 4'b0000;
        case (e.st)
            S_FETCH:  begin req = 1; sb = 2'b01; alu = 4'b0010; irw = e.rdy; pcw = e.rdy; end
            S_DECODE: begin sb = 2'b11; alu = 4'b0010; end
            S_MEMADR, S_ADDIEX: begin sa = 1; sb = 2'b10; alu = 4'b0010; end
            S_MEMRD:  begin req = 1; io = 1; end
            S_MEMWR:  begin req = 1; io = 1; mw = e.rdy; end
            S_MEMWB:  begin rw = 1; m2r = 1; end
            S_EXEC:   begin sa = 1; alu = r_alu(fn) [3:0]; end
            S_ALUWB:  begin rw = 1; rd = 1; end
            S_BEQ:    begin sa = 1; alu = 4'b0110; br = 1; ps = 2'b01; end
            S_ADDIWB: rw = 1;
            S_JUMP:   begin pcw = 1; ps = 2'b10; end
            S_LUIEX:  begin imm = 1; skip = 1; rw = 1; end
            default: ;
        endcase
        return {req, io, mw, irw, pcw, br, rw, rd, m2r, sa, sb, ps, alu, imm, skip, e.ill, e.berr};
    endfunction

    task automatic push(input logic [3:0] st, input logic rdy);
        plan.push_back('{st: st, rdy: rdy, ill: pend_ill, berr: pend_berr});
        pend_ill  = 1'b0;
        pend_berr = 1'b0;
    endtask

    // w not-ready cycles, then a ready one; w >= TMO means the access times out.
    task automatic add_wait(input logic [3:0] st, input int w, output bit ok);
        if (w >= TMO) begin
            for (int i = 0; i < TMO; i++) push(st, 1'b0);
            pend_berr = 1'b1;
            ok = 0;
        end else begin
            for (int i = 0; i < w; i++) push(st, 1'b0);
            push(st, 1'b1);
            ok = 1;
        end
    endtask

    task automatic plan_instr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw);
        bit ok;
        add_wait(S_FETCH, fw, ok);
        if (!ok) return;
        push(S_DECODE, 1'($urandom_range(0, 1)));
        case (op)
            OP_LW: begin
                push(S_MEMADR, 1'($urandom_range(0, 1)));
                add_wait(S_MEMRD, mw, ok);
                if (ok) push(S_MEMWB, 1'($urandom_range(0, 1)));
            end
            OP_SW: begin
                push(S_MEMADR, 1'($urandom_range(0, 1)));
                add_wait(S_MEMWR, mw, ok);
            end
            OP_R: begin
                push(S_EXEC, 1'($urandom_range(0, 1)));
                if (r_alu(fn) [4]) push(S_ALUWB, 1'($urandom_range(0, 1)));
                else pend_ill = 1'b1;
            end
            OP_BEQ:  push(S_BEQ, 1'($urandom_range(0, 1)));
            OP_ADDI: begin
                push(S_ADDIEX, 1'($urandom_range(0, 1)));
                push(S_ADDIWB, 1'($urandom_range(0, 1)));
            end
            OP_J:    push(S_JUMP, 1'($urandom_range(0, 1)));
`ifdef MC_CTRL_LUI_EN
            OP_LUI:  push(S_LUIEX, 1'($urandom_range(0, 1)));
`endif
            default: pend_ill = 1'b1;
        endcase
    endtask

    // Entered and left at posedge+1; outputs sampled on the falling edge.
    task automatic run_plan(input logic [5:0] op, input logic [5:0] fn);
        cyc_t e;
        opcode_i6 = op;
        funct_i6  = fn;
        while (plan.size() > 0) begin
            e = plan.pop_front();
            mem_ready_i = e.rdy;
            zero_i      = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("state", 32'(state_o4), 32'(e.st));
            chk("outputs", 32'(dut_outs()), 32'(exp_outs(e, fn)));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw);
        plan_instr(op, fn, fw, mw);
        run_plan(op, fn);
    endtask

    function automatic int pick_wait();
        int r = $urandom_range(0, 7);
        if (r == 0) return TMO;
        if (r == 1) return TMO - 1;
        return $urandom_range(0, 3);
    endfunction

    logic [5:0] ops[8];
    logic [5:0] fns[6];

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        pend_ill  = 1'b0;
        pend_berr = 1'b0;
        ops = '{OP_LW, OP_SW, OP_R, OP_BEQ, OP_ADDI, OP_J, OP_LUI, 6'b111111};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};

        reset_ni    = 1'b0;
        mem_ready_i = 1'b1;
        opcode_i6   = OP_LW;
        funct_i6    = 6'b0;
        zero_i      = 1'b0;
        #2;
        chk("rst_state", 32'(state_o4), 32'(S_FETCH));
        chk("rst_strobes", 32'({ir_write_o, pc_write_o, mem_write_o, reg_write_o}), 32'd0);
        chk("rst_errs", 32'({illegal_o, bus_err_o}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_ni = 1'b1;

        do_instr(OP_LW, 6'b0, 0, 0);               // plain lw
        do_instr(OP_R, 6'b100000, 3, 0);           // add with 3-cycle fetch stall
        do_instr(OP_BEQ, 6'b0, 0, 0);
        do_instr(6'b111111, 6'b0, 1, 0);           // illegal opcode
        do_instr(OP_R, 6'b000111, 0, 0);           // illegal funct
        do_instr(OP_SW, 6'b0, 0, TMO);             // store times out
        do_instr(OP_LW, 6'b0, 2, TMO - 1);         // ready on the last allowed cycle
        do_instr(OP_ADDI, 6'b0, TMO, 0);           // fetch times out
        do_instr(OP_J, 6'b0, 0, 0);
        do_instr(OP_LUI, 6'b0, 0, 0);

        for (int n = 0; n < 200; n++) begin
            logic [5:0] op, fn;
            op = ops[$urandom_range(0, 7)];
            if ($urandom_range(0, 7) == 0) op = 6'($urandom());
            fn = fns[$urandom_range(0, 5)];
            if ($urandom_range(0, 7) == 0) fn = 6'($urandom());
            do_instr(op, fn, pick_wait(), pick_wait());
        end
        push(S_FETCH, 1'b0);                       // observe any trailing error pulse
        run_plan(OP_LW, 6'b0);

        // Reset in the middle of a load, with memory signalling ready.
        opcode_i6   = OP_LW;
        mem_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_memrd", 32'(state_o4), 32'(S_MEMRD));
        #2;
        reset_ni = 1'b0;
        #1;
        chk("mid_rst_state", 32'(state_o4), 32'(S_FETCH));
        chk("mid_rst_strobes", 32'({ir_write_o, pc_write_o, mem_write_o, reg_write_o}), 32'd0);
        chk("mid_rst_errs", 32'({illegal_o, bus_err_o}), 32'd0);
        @(posedge clk);
        #1;
        chk("hold_rst_state", 32'(state_o4), 32'(S_FETCH));
        chk("hold_rst_strobes", 32'({ir_write_o, pc_write_o, mem_write_o, reg_write_o}), 32'd0);
        reset_ni = 1'b1;
        do_instr(OP_LUI, 6'b0, 1, 0);
        do_instr(OP_LW, 6'b0, 0, 1);
        push(S_FETCH, 1'b0);
        run_plan(OP_LW, 6'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
